// File: rtl/riscv_rf_pkg.sv
// riscv_rf_pkg: shared widths and the writeback entry type for the RF write-port scheduler.
package riscv_rf_pkg;
    localparam int WID_DATA = 32;
    localparam int WID_ADD = 5;
    localparam int NREG = 32;
    localparam logic [WID_ADD-1:0] X0 = '0;
    typedef struct packed {
        logic [WID_ADD-1:0] rd;
        logic [WID_DATA-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: decode, ALU/load writeback and RF write-control signals.
interface regfile_wb_scheduler_if;
    import riscv_rf_pkg::*;
    logic issue_valid;
    logic [WID_ADD-1:0] issue_rs1;
    logic [WID_ADD-1:0] issue_rs2;
    logic [WID_ADD-1:0] issue_rd;
    logic issue_we;
    logic issue_stall;
    logic alu_valid;
    logic [WID_ADD-1:0] alu_rd;
    logic [WID_DATA-1:0] alu_data;
    logic alu_ready;
    logic ld_valid;
    logic [WID_ADD-1:0] ld_rd;
    logic [WID_DATA-1:0] ld_data;
    logic [WID_ADD-1:0] rf_rd;
    logic [WID_DATA-1:0] rf_datain;
    logic rf_we;
    logic [NREG-1:0] busy_vec;
    logic err_sticky;
    modport slave (
        input issue_valid, issue_rs1, issue_rs2, issue_rd, issue_we,
        input alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_stall, alu_ready, rf_rd, rf_datain, rf_we, busy_vec, err_sticky
    );
    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_we,
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input issue_stall, alu_ready, rf_rd, rf_datain, rf_we, busy_vec, err_sticky
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO holding ALU writebacks that lost the RF port.
module wb_fifo
    import riscv_rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic wr, rd;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        wr = push & !full;
        rd = pop & !empty;
        mem_d = mem_q;
        wp_d = wp_q;
        rp_d = rd ? inc(rp_q) : rp_q;
        if (wr) begin
            mem_d[wp_q] = din;
            wp_d = inc(wp_q);
        end
        cnt_d = cnt_q + CW'(wr) - CW'(rd);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout = mem_q[rp_q];
    assign full = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: busy scoreboard, decode hazard stall and arbitration of the single
// RF write port between load and ALU writeback, driven from a registered W stage.
module regfile_wb_scheduler
    import riscv_rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst_n,
    regfile_wb_scheduler_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    logic [NREG-1:0] busy_q, busy_d;
    logic [WID_ADD-1:0] rf_rd_q, rf_rd_d;
    logic [WID_DATA-1:0] rf_data_q, rf_data_d;
    logic rf_we_q, rf_we_d, err_q, err_d;
    wb_entry_t head, alu_e;
    logic full, empty, push, pop, sel_ld, alu_acc, bypass, issue_fire;
    logic [CW-1:0] count;
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(alu_e),
        .dout(head), .full(full), .empty(empty), .count(count)
    );
    assign bus.issue_stall = bus.issue_valid & (busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2]
                             | (bus.issue_we & busy_q[bus.issue_rd]));
    assign bus.alu_ready = !full;
    always_comb begin
        alu_e = '{rd: bus.alu_rd, data: bus.alu_data};
        issue_fire = bus.issue_valid & !bus.issue_stall & bus.issue_we;
        sel_ld = bus.ld_valid & (bus.ld_rd != X0);
        alu_acc = bus.alu_valid & !full & (bus.alu_rd != X0);
        pop = !sel_ld & !empty;
        // an idle port with an empty FIFO lets the ALU result go straight to W
        bypass = !sel_ld & (count == '0) & alu_acc;
        push = alu_acc & !bypass;
        rf_we_d = sel_ld | pop | bypass;
        rf_rd_d = sel_ld ? bus.ld_rd : pop ? head.rd : bypass ? bus.alu_rd : rf_rd_q;
        rf_data_d = sel_ld ? bus.ld_data : pop ? head.data : bypass ? bus.alu_data : rf_data_q;
        busy_d = busy_q;
        if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
        if (issue_fire) busy_d[bus.issue_rd] = 1'b1;
        busy_d[X0] = 1'b0;
        err_d = err_q | (rf_we_q & !busy_q[rf_rd_q]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            rf_rd_q <= '0;
            rf_data_q <= '0;
            rf_we_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            rf_rd_q <= rf_rd_d;
            rf_data_q <= rf_data_d;
            rf_we_q <= rf_we_d;
            err_q <= err_d;
        end
    end
    assign bus.rf_rd = rf_rd_q;
    assign bus.rf_datain = rf_data_q;
    assign bus.rf_we = rf_we_q;
    assign bus.busy_vec = busy_q;
    assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed vectors and hand-written sequences for the RF write scheduler.
module tb_regfile_wb_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    regfile_wb_scheduler_if bus();
    regfile_wb_scheduler #(.FIFO_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic v;
        logic [4:0] rs1, rs2, rd;
        logic we;
        logic exp;
    } stall_vec_t;
    stall_vec_t tv [8];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 0; bus.issue_we = 0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
    endtask
    task automatic issue_wr(input logic [4:0] r);
        bus.issue_valid = 1; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = r; bus.issue_we = 1;
        step();
        bus.issue_valid = 0; bus.issue_we = 0;
    endtask
    task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.alu_valid = v; bus.alu_rd = r; bus.alu_data = d;
    endtask
    task automatic ld(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.ld_valid = v; bus.ld_rd = r; bus.ld_data = d;
    endtask
    initial begin
        tv[0] = '{1, 5'd5, 5'd0, 5'd0, 0, 1};
        tv[1] = '{1, 5'd0, 5'd6, 5'd0, 0, 1};
        tv[2] = '{1, 5'd1, 5'd2, 5'd5, 1, 1};
        tv[3] = '{1, 5'd1, 5'd2, 5'd5, 0, 0};
        tv[4] = '{0, 5'd5, 5'd6, 5'd5, 1, 0};
        tv[5] = '{1, 5'd0, 5'd0, 5'd0, 1, 0};
        tv[6] = '{1, 5'd7, 5'd8, 5'd9, 1, 0};
        tv[7] = '{1, 5'd6, 5'd6, 5'd0, 0, 1};
        idle();
        step(); step();
        rst_n = 1;
        step();
        chk("reset_busy", 64'(bus.busy_vec), 0);
        chk("reset_we", 64'(bus.rf_we), 0);
        chk("reset_rd", 64'(bus.rf_rd), 0);
        chk("reset_data", 64'(bus.rf_datain), 0);
        chk("reset_err", 64'(bus.err_sticky), 0);
        // reset mid-flight: x5,x6 busy with two FIFO entries queued behind loads
        issue_wr(5); issue_wr(6);
        ld(1, 5'd1, 32'h1); alu(1, 5'd5, 32'h55); step();
        alu(1, 5'd6, 32'h66); step();
        idle();
        chk("t1_full_ready", 64'(bus.alu_ready), 0);
        chk("t1_busy_pre", 64'(bus.busy_vec), 64'h60);
        rst_n = 0;
        #1;
        chk("t1_rst_busy", 64'(bus.busy_vec), 0);
        chk("t1_rst_we", 64'(bus.rf_we), 0);
        chk("t1_rst_ready", 64'(bus.alu_ready), 1);
        chk("t1_rst_err", 64'(bus.err_sticky), 0);
        step();
        rst_n = 1;
        step();
        chk("t1_post_we0", 64'(bus.rf_we), 0);
        step();
        chk("t1_post_we1", 64'(bus.rf_we), 0);
        chk("t1_post_busy", 64'(bus.busy_vec), 0);
        // stall table against busy x5,x6
        issue_wr(5); issue_wr(6);
        for (int i = 0; i < 8; i++) begin
            bus.issue_valid = tv[i].v; bus.issue_rs1 = tv[i].rs1; bus.issue_rs2 = tv[i].rs2;
            bus.issue_rd = tv[i].rd; bus.issue_we = tv[i].we;
            #1;
            chk($sformatf("stall_vec%0d", i), 64'(bus.issue_stall), 64'(tv[i].exp));
        end
        idle();
        alu(1, 5'd5, 32'h5); step();
        alu(1, 5'd6, 32'h6); step();
        idle(); step();
        chk("tbl_cleanup_busy", 64'(bus.busy_vec), 0);
        chk("tbl_cleanup_err", 64'(bus.err_sticky), 0);
        // RAW stall released two cycles after ALU result arrives
        issue_wr(5);
        bus.issue_valid = 1; bus.issue_rs1 = 5; bus.issue_we = 0;
        alu(1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("t2_stall_n", 64'(bus.issue_stall), 1);
        chk("t2_ready_n", 64'(bus.alu_ready), 1);
        step();
        alu(0, 5'd0, 32'h0);
        chk("t2_we_n1", 64'(bus.rf_we), 1);
        chk("t2_rd_n1", 64'(bus.rf_rd), 5);
        chk("t2_data_n1", 64'(bus.rf_datain), 64'hDEADBEEF);
        chk("t2_stall_n1", 64'(bus.issue_stall), 1);
        step();
        chk("t2_stall_n2", 64'(bus.issue_stall), 0);
        chk("t2_busy_n2", 64'(bus.busy_vec[5]), 0);
        idle();
        // load wins over a same-cycle ALU result
        issue_wr(3); issue_wr(4);
        ld(1, 5'd3, 32'h11); alu(1, 5'd4, 32'h22); step();
        idle();
        chk("t3_rd_n1", 64'(bus.rf_rd), 3);
        chk("t3_data_n1", 64'(bus.rf_datain), 64'h11);
        chk("t3_busy_n1", 64'(bus.busy_vec[4:3]), 64'h3);
        step();
        chk("t3_we_n2", 64'(bus.rf_we), 1);
        chk("t3_rd_n2", 64'(bus.rf_rd), 4);
        chk("t3_data_n2", 64'(bus.rf_datain), 64'h22);
        chk("t3_busy_n2", 64'(bus.busy_vec[4:3]), 64'h2);
        step();
        chk("t3_we_n3", 64'(bus.rf_we), 0);
        chk("t3_hold_rd", 64'(bus.rf_rd), 4);
        chk("t3_hold_data", 64'(bus.rf_datain), 64'h22);
        chk("t3_busy_n3", 64'(bus.busy_vec), 0);
        // three loads back to back fill the FIFO
        for (int r = 10; r < 16; r++) issue_wr(5'(r));
        ld(1, 5'd13, 32'hA0); alu(1, 5'd10, 32'hB0); step();
        ld(1, 5'd14, 32'hA1); alu(1, 5'd11, 32'hB1);
        #1;
        chk("t4_ready1", 64'(bus.alu_ready), 1);
        chk("t4_ld13", 64'(bus.rf_rd), 13);
        step();
        ld(1, 5'd15, 32'hA2); alu(1, 5'd12, 32'hB2);
        #1;
        chk("t4_ready_full", 64'(bus.alu_ready), 0);
        step();
        ld(0, 5'd0, 32'h0);
        #1;
        chk("t4_no_passthru", 64'(bus.alu_ready), 0);
        chk("t4_ld15", 64'(bus.rf_rd), 15);
        step();
        chk("t4_e0_rd", 64'(bus.rf_rd), 10);
        chk("t4_e0_data", 64'(bus.rf_datain), 64'hB0);
        chk("t4_ready_again", 64'(bus.alu_ready), 1);
        step();
        idle();
        chk("t4_e1_rd", 64'(bus.rf_rd), 11);
        chk("t4_e1_data", 64'(bus.rf_datain), 64'hB1);
        step();
        chk("t4_e2_rd", 64'(bus.rf_rd), 12);
        chk("t4_e2_data", 64'(bus.rf_datain), 64'hB2);
        step();
        chk("t4_idle_we", 64'(bus.rf_we), 0);
        chk("t4_busy", 64'(bus.busy_vec), 0);
        chk("t4_err", 64'(bus.err_sticky), 0);
        // x0 never becomes busy and never reaches the RF
        bus.issue_valid = 1; bus.issue_rd = 0; bus.issue_we = 1;
        #1;
        chk("t5_stall_rd0", 64'(bus.issue_stall), 0);
        step();
        bus.issue_we = 0; bus.issue_rs1 = 0;
        chk("t5_busy", 64'(bus.busy_vec), 0);
        alu(1, 5'd0, 32'h55);
        #1;
        chk("t5_stall_rs0", 64'(bus.issue_stall), 0);
        chk("t5_ready", 64'(bus.alu_ready), 1);
        step();
        idle();
        chk("t5_we_a", 64'(bus.rf_we), 0);
        ld(1, 5'd0, 32'h99); step();
        idle();
        chk("t5_we_b", 64'(bus.rf_we), 0);
        chk("t5_busy_end", 64'(bus.busy_vec), 0);
        // write to a register that was never marked busy
        alu(1, 5'd7, 32'h77); step();
        idle();
        chk("t6_we", 64'(bus.rf_we), 1);
        chk("t6_rd", 64'(bus.rf_rd), 7);
        chk("t6_data", 64'(bus.rf_datain), 64'h77);
        chk("t6_err_pre", 64'(bus.err_sticky), 0);
        step();
        chk("t6_err_set", 64'(bus.err_sticky), 1);
        step(); step();
        chk("t6_err_sticky", 64'(bus.err_sticky), 1);
        rst_n = 0;
        #1;
        chk("t6_err_rst", 64'(bus.err_sticky), 0);
        step();
        rst_n = 1;
        step();
        chk("t6_err_after", 64'(bus.err_sticky), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
